// File: rtl/gpr_file_2r1w.sv
// gpr_file_2r1w: WIDTH x DEPTH register file, two combinational read ports, one synchronous write port.
// Optional hardwired-zero register 0 and same-cycle write-to-read forwarding.
module gpr_file_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wvalid;
    logic [AW-1:0]    ra [2];
    logic [WIDTH-1:0] rd [2];

    // A write that will actually land; also the only write eligible for forwarding.
    assign wvalid = we && !rst && ({1'b0, waddr} < LIM) && !(ZERO_REG != 0 && waddr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        else if (wvalid)
            regs[waddr] <= wdata;
    end

    assign ra[0] = raddr1;
    assign ra[1] = raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign rd[p] = ({1'b0, ra[p]} >= LIM || (ZERO_REG != 0 && ra[p] == '0)) ? '0 :
                       (BYPASS != 0 && wvalid && waddr == ra[p]) ? wdata : regs[ra[p]];
    end

    assign rdata1 = rd[0];
    assign rdata2 = rd[1];
endmodule

// File: tb/tb_gpr_file_2r1w.sv
// tb_gpr_file_2r1w: table vectors plus scoreboarded sequences on three configurations
// (default, no forwarding, 24-entry) sharing one stimulus stream.
`timescale 1ns/1ps
module tb_gpr_file_2r1w;
    logic clk = 0, rst = 0, we = 0;
    logic [4:0] waddr = 0, raddr1 = 0, raddr2 = 0;
    logic [31:0] wdata = 0;
    logic [31:0] r1 [3];
    logic [31:0] r2 [3];
    logic [31:0] m [3][32];
    int passed = 0, total = 0;

    typedef struct {string name; int inst; logic [31:0] e1; logic [31:0] e2;} exp_t;
    typedef struct {logic we; logic [4:0] wa; logic [31:0] wd; logic [4:0] a1; logic [4:0] a2;
                    logic [31:0] e1; logic [31:0] e2;} vec_t;
    exp_t sbq[$];
    vec_t vt[10];

    always #5 clk = ~clk;

    gpr_file_2r1w d0 (.clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
                      .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1[0]), .rdata2(r2[0]));
    gpr_file_2r1w #(.BYPASS(0)) d1 (.clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
                      .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1[1]), .rdata2(r2[1]));
    gpr_file_2r1w #(.DEPTH(24)) d2 (.clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
                      .raddr1(raddr1), .raddr2(raddr2), .rdata1(r1[2]), .rdata2(r2[2]));

    function automatic int dep(int i);
        return i == 2 ? 24 : 32;
    endfunction

    function automatic logic [31:0] mrd(int i, logic [4:0] a);
        if (int'(a) >= dep(i) || a == 0) return 0;
        if (i != 1 && we && !rst && waddr == a) return wdata;
        return m[i][a];
    endfunction

    task automatic clr();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 32; j++) m[i][j] = 0;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(string name);
        for (int i = 0; i < 3; i++) sbq.push_back('{name, i, mrd(i, raddr1), mrd(i, raddr2)});
    endtask

    task automatic drain();
        exp_t e;
        #0.2;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("%s/u%0d/rd1", e.name, e.inst), r1[e.inst], e.e1);
            check($sformatf("%s/u%0d/rd2", e.name, e.inst), r2[e.inst], e.e2);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        if (!rst && we)
            for (int i = 0; i < 3; i++)
                if (int'(waddr) < dep(i) && waddr != 0) m[i][waddr] = wdata;
        #1;
    endtask

    task automatic sweep(string name);
        for (int a = 0; a < 16; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(a + 16);
            push(name);
            drain();
        end
    endtask

    initial begin
        vt[0] = '{1'b1, 5'd5,  32'h1234_5678, 5'd5,  5'd31, 32'h1234_5678, 32'h0};
        vt[1] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 5'd5,  5'd31, 32'h1234_5678, 32'hDEAD_BEEF};
        vt[2] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd31, 32'h1234_5678, 32'hDEAD_BEEF};
        vt[3] = '{1'b1, 5'd0,  32'hAAAA_AAAA, 5'd0,  5'd0,  32'h0,         32'h0};
        vt[4] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0,         32'h1234_5678};
        vt[5] = '{1'b1, 5'd7,  32'h11,        5'd7,  5'd7,  32'h11,        32'h11};
        vt[6] = '{1'b1, 5'd7,  32'h22,        5'd7,  5'd7,  32'h22,        32'h22};
        vt[7] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  32'h22,        32'h22};
        vt[8] = '{1'b1, 5'd28, 32'h55,        5'd28, 5'd5,  32'h55,        32'h1234_5678};
        vt[9] = '{1'b0, 5'd0,  32'h0,         5'd28, 5'd31, 32'h55,        32'hDEAD_BEEF};
        clr();
        #1 rst = 1;
        edge_();
        rst = 0;
        sweep("reset");
        for (int k = 0; k < 10; k++) begin
            we = vt[k].we; waddr = vt[k].wa; wdata = vt[k].wd;
            raddr1 = vt[k].a1; raddr2 = vt[k].a2;
            push($sformatf("vec%0d", k));
            sbq.push_back('{$sformatf("vec%0d_tbl", k), 0, vt[k].e1, vt[k].e2});
            drain();
            edge_();
        end
        // Preload, then async reset mid-cycle must clear before the next edge.
        for (int a = 1; a < 32; a++) begin
            we = 1; waddr = 5'(a); wdata = '1;
            edge_();
        end
        we = 0;
        rst = 1; clr();
        we = 1; waddr = 3; wdata = 32'h77;
        sweep("async_rst");
        edge_();
        #2 rst = 0; we = 0;
        sweep("post_rst");
        edge_();
        // rst released just before an edge: that write lands.
        rst = 1; clr();
        we = 1; waddr = 9; wdata = 32'hCAFE_F00D;
        #7 rst = 0;
        #1 raddr1 = 9; raddr2 = 9;
        push("late_rel_pre");
        drain();
        edge_();
        we = 0;
        push("late_rel_post");
        drain();
        for (int c = 0; c < 10000; c++) begin
            we = 1'($urandom);
            waddr = 5'($urandom);
            wdata = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            push("rand");
            drain();
            if ($urandom_range(0, 199) == 0) begin
                rst = 1; clr();
                push("rand_rst");
                drain();
                rst = 0;
                push("rand_rst_rel");
                drain();
            end
            edge_();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
